timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
//   Memory-mapped countdown timer that answers system-bridge accesses: decodes a word
//   offset, services register reads/writes, and raises an interrupt line at count expiry.
//   One instance sits behind each timer window of the bridge. Its read data and irq
//   return through the bridge to the CPU as pr_rd and a hwint bit.
// PARAMETERS
//   RESET_PRESET  32'h0000_0000  PRESET value after reset
// PORTS
//   clk      in   1   system clock, all state updates on rising edge
//   reset_n  in   1   asynchronous, active-low reset
//   addr     in   2   word offset within window (byte addr[3:2]): 0=CTRL 1=PRESET 2=COUNT
//   we       in   1   write strobe from bridge (already window-qualified)
//   din      in   32  write data
//   dout     out  32  read data, combinational from addr
//   irq      out  1   interrupt request to bridge
// BEHAVIOUR
// - Reset (async, any time incl. mid-count):
//   CTRL=0, PRESET=RESET_PRESET, COUNT=0, state=IDLE, irq_flag=0, irq=0.
// - CTRL[0] EN: count enable.
//   CTRL[2:1] MODE: 00 one-shot, 01 auto-reload; 10/11 behave as 00.
//   CTRL[3] IM: interrupt mask (1 = irq allowed). CTRL[31:4] read 0, writes ignored.
// - Reads: dout = CTRL/PRESET/COUNT per addr; addr=3 returns 0; no side effects.
// - Writes:
//   addr0 loads CTRL[3:0] and clears irq_flag.
//   addr1 loads PRESET.
//   addr2/addr3 are ignored (COUNT is read-only).
// - irq = irq_flag & CTRL[3] (combinational).
// - FSM, one transition per clock. Checks use values before the edge:
//   IDLE: EN=1 -> LOAD.
//   LOAD: COUNT<=PRESET; -> CNT (EN=0 -> IDLE, COUNT still loaded).
//   CNT:  EN=0 -> IDLE, COUNT frozen.
//         COUNT>1 -> COUNT<=COUNT-1, stay.
//         COUNT<=1 -> COUNT<=0, irq_flag<=1, -> INT.
//   INT:  MODE=01 -> irq_flag<=0, -> LOAD (irq is a one-cycle pulse per period).
//         else -> CTRL[0]<=0, -> IDLE (irq_flag held until CTRL write or reset).
// - Latency: EN write at edge E0 gives LOAD after E0, COUNT=PRESET after E1,
//   and INT entered at edge E1+max(PRESET,1).
//   Reload period in mode 01 = max(PRESET,1)+2 cycles.
// - Simultaneous events:
//   CPU CTRL write beats FSM changes to CTRL (INT clearing EN) and to irq_flag (set in CNT).
//   PRESET written in the same cycle as LOAD: LOAD takes the old PRESET; the next reload
//   uses the new one.
//   CTRL write with EN=0 during CNT: COUNT frozen, state IDLE next edge.
//   Writing EN=1 again restarts from LOAD (no resume).
// - Width: COUNT is 32-bit unsigned and never decrements below 0 (no wrap).
//   PRESET=0 acts as PRESET=1.
// TESTING
// - Reset with no access -> dout=0 for addr0/2; PRESET reads RESET_PRESET; irq=0.
//   Assert reset_n low mid-CNT -> COUNT=0, irq=0 immediately, before any clock edge.
// - PRESET=5, CTRL=4'b1001 -> COUNT reads 5,4,3,2,1 on successive cycles, then 0.
//   irq rises on the 6th edge after the LOAD edge; CTRL reads 4'b1000; irq stays high
//   until CTRL is written with 0.
// - PRESET=3, CTRL=4'b1011 -> irq is a 1-cycle pulse every 5 cycles.
//   4 pulses in 20 cycles; COUNT reloads to 3.
// - PRESET=10, enable, write CTRL=0 when COUNT=6 -> COUNT holds 6, no irq.
//   Re-enable -> COUNT=10 after two edges.
// - IM=0, mode 00, PRESET=2 -> irq never asserts.
//   Then write CTRL=4'b1000 -> irq_flag cleared, so irq still 0.
// - Write COUNT=0x1234 and addr3 -> COUNT unchanged; addr3 reads 0.
//   CTRL write that lands on the CNT->INT edge -> written CTRL kept and irq_flag=0.

Source files
------------

// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - bridge-side register window of one countdown timer
interface timer_counter_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output addr, we, din, input dout, irq);
    modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped countdown timer with one-shot/auto-reload and irq
module timer_counter #(
    parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    timer_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  ctrl;
    logic [3:0]  ctrl_nxt;
    logic [3:0]  ctrl_eff;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_nxt;
    logic        irq_flag;
    logic        irq_flag_nxt;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        en_eff;
    logic        reload_mode;

    assign ctrl_wr   = bus.we && (bus.addr == 2'd0);
    assign preset_wr = bus.we && (bus.addr == 2'd1);

    // The FSM sees a CTRL value being written this cycle, so an EN write acts on its own edge.
    assign ctrl_eff    = ctrl_wr ? bus.din[3:0] : ctrl;
    assign en_eff      = ctrl_eff[0];
    assign reload_mode = (ctrl_eff[2:1] == 2'b01);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (en_eff) state_nxt = S_LOAD;
            S_LOAD: state_nxt = en_eff ? S_CNT : S_IDLE;
            S_CNT: begin
                if (!en_eff) begin
                    state_nxt = S_IDLE;
                end else if (count <= 32'd1) begin
                    state_nxt = S_INT;
                end
            end
            S_INT:   state_nxt = reload_mode ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        count_nxt    = count;
        irq_flag_nxt = irq_flag;
        ctrl_nxt     = ctrl_eff;
        case (state)
            S_LOAD: count_nxt = preset;
            S_CNT: begin
                if (en_eff) begin
                    if (count > 32'd1) begin
                        count_nxt = count - 32'd1;
                    end else begin
                        count_nxt    = 32'd0;
                        irq_flag_nxt = 1'b1;
                    end
                end
            end
            S_INT: begin
                if (reload_mode) begin
                    irq_flag_nxt = 1'b0;
                end else begin
                    ctrl_nxt[0] = 1'b0;
                end
            end
            default: ;
        endcase
        // A CPU write to CTRL wins over anything the FSM does to CTRL or the flag.
        if (ctrl_wr) begin
            ctrl_nxt     = bus.din[3:0];
            irq_flag_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl     <= 4'd0;
            preset   <= RESET_PRESET;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            ctrl     <= ctrl_nxt;
            count    <= count_nxt;
            irq_flag <= irq_flag_nxt;
            if (preset_wr) begin
                preset <= bus.din;
            end
        end
    end

    always_comb begin
        case (bus.addr)
            2'd0:    bus.dout = {28'd0, ctrl};
            2'd1:    bus.dout = preset;
            2'd2:    bus.dout = count;
            default: bus.dout = 32'd0;
        endcase
    end

    assign bus.irq = irq_flag & ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed and randomized bench for timer_counter
module tb_timer_counter;

    localparam logic [31:0] RST_PRESET = 32'h0000_00A5;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    timer_counter_if bus();

    timer_counter #(.RESET_PRESET(RST_PRESET)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 loading, 2 running, 3 expired.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_phase;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl   = 4'd0;
        m_preset = RST_PRESET;
        m_count  = 32'd0;
        m_flag   = 1'b0;
        m_phase  = 0;
    endtask

    task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
        logic [3:0] c;
        logic       cpu_ctrl;
        cpu_ctrl = w && (a == 2'd0);
        c = cpu_ctrl ? d[3:0] : m_ctrl;
        case (m_phase)
            0: if (c[0]) m_phase = 1;
            1: begin
                m_count = m_preset;
                m_phase = c[0] ? 2 : 0;
            end
            2: begin
                if (!c[0]) begin
                    m_phase = 0;
                end else if (m_count > 1) begin
                    m_count = m_count - 1;
                end else begin
                    m_count = 0;
                    m_flag  = 1'b1;
                    m_phase = 3;
                end
            end
            default: begin
                if (c[2:1] == 2'b01) begin
                    m_flag  = 1'b0;
                    m_phase = 1;
                end else begin
                    if (!cpu_ctrl) c[0] = 1'b0;
                    m_phase = 0;
                end
            end
        endcase
        m_ctrl = c;
        if (cpu_ctrl) m_flag = 1'b0;
        if (w && a == 2'd1) m_preset = d;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick(input logic w, input logic [1:0] a, input logic [31:0] d);
        bus.we   = w;
        bus.addr = a;
        bus.din  = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic tick0();
        tick(1'b0, 2'd0, 32'd0);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus.addr = a;
        #1;
        v = bus.dout;
    endtask

    logic [31:0] v;
    logic [31:0] held;
    int          pulses;
    int          first_pulse;
    int          last_pulse;
    int          gap_bad;
    int          irq_seen;
    int          guard;
    bit          found;

    initial begin
        reset_n  = 1'b0;
        bus.we   = 1'b0;
        bus.addr = 2'd0;
        bus.din  = 32'd0;
        model_reset();
        #12;
        reset_n = 1'b1;

        // Reset state
        rd(2'd0, v); check("rst_ctrl", v, 32'd0);
        rd(2'd1, v); check("rst_preset", v, RST_PRESET);
        rd(2'd2, v); check("rst_count", v, 32'd0);
        check("rst_irq", {31'd0, bus.irq}, 32'd0);

        // One-shot, PRESET=5
        tick(1'b1, 2'd1, 32'd5);
        tick(1'b1, 2'd0, 32'h9);
        for (int i = 5; i >= 1; i--) begin
            tick0();
            rd(2'd2, v); check("oneshot_count", v, 32'(i));
            check("oneshot_irq_low", {31'd0, bus.irq}, 32'd0);
        end
        tick0();
        rd(2'd2, v); check("oneshot_count_zero", v, 32'd0);
        check("oneshot_irq_rise", {31'd0, bus.irq}, 32'd1);
        tick0();
        rd(2'd0, v); check("oneshot_ctrl_en_cleared", v, 32'h8);
        for (int i = 0; i < 3; i++) tick0();
        check("oneshot_irq_held", {31'd0, bus.irq}, 32'd1);
        tick(1'b1, 2'd0, 32'd0);
        check("oneshot_irq_cleared", {31'd0, bus.irq}, 32'd0);

        // Auto-reload, PRESET=3: period 5
        tick(1'b1, 2'd1, 32'd3);
        tick(1'b1, 2'd0, 32'hB);
        pulses = 0; first_pulse = -1; last_pulse = -1; gap_bad = 0;
        for (int e = 1; e <= 20; e++) begin
            tick0();
            if (bus.irq) begin
                if (last_pulse >= 0 && e - last_pulse != 5) gap_bad++;
                if (first_pulse < 0) first_pulse = e;
                last_pulse = e;
                pulses++;
            end
            if (e == 6) begin
                rd(2'd2, v); check("reload_count", v, 32'd3);
            end
        end
        check("reload_pulses", 32'(pulses), 32'd4);
        check("reload_first_pulse", 32'(first_pulse), 32'd4);
        check("reload_gap", 32'(gap_bad), 32'd0);
        tick(1'b1, 2'd0, 32'd0);

        // Disable mid-count freezes COUNT, re-enable restarts from LOAD
        tick(1'b1, 2'd1, 32'd10);
        tick(1'b1, 2'd0, 32'h1);
        found = 1'b0;
        guard = 0;
        while (!found && guard < 20) begin
            tick0();
            rd(2'd2, v);
            if (v == 32'd6) found = 1'b1;
            guard++;
        end
        check("freeze_reach_6", {31'd0, found}, 32'd1);
        tick(1'b1, 2'd0, 32'd0);
        rd(2'd2, v); check("freeze_hold", v, 32'd6);
        for (int i = 0; i < 3; i++) tick0();
        rd(2'd2, v); check("freeze_hold_later", v, 32'd6);
        check("freeze_irq", {31'd0, bus.irq}, 32'd0);
        tick(1'b1, 2'd0, 32'h1);
        tick0();
        rd(2'd2, v); check("restart_count", v, 32'd10);
        tick(1'b1, 2'd0, 32'd0);

        // COUNT is read-only, addr3 is empty
        rd(2'd2, held);
        tick(1'b1, 2'd2, 32'h1234);
        rd(2'd2, v); check("count_ro", v, held);
        tick(1'b1, 2'd3, 32'hFFFF_FFFF);
        rd(2'd3, v); check("addr3_zero", v, 32'd0);
        rd(2'd0, v); check("addr3_no_ctrl", v, 32'd0);

        // Masked interrupt
        tick(1'b1, 2'd1, 32'd2);
        tick(1'b1, 2'd0, 32'h1);
        irq_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick0();
            if (bus.irq) irq_seen++;
        end
        check("mask_no_irq", 32'(irq_seen), 32'd0);
        rd(2'd0, v); check("mask_en_cleared", v, 32'd0);
        tick(1'b1, 2'd0, 32'h8);
        check("mask_flag_cleared", {31'd0, bus.irq}, 32'd0);
        rd(2'd0, v); check("mask_ctrl", v, 32'h8);
        tick(1'b1, 2'd0, 32'd0);

        // CTRL write on the expiry edge
        tick(1'b1, 2'd1, 32'd2);
        tick(1'b1, 2'd0, 32'h9);
        found = 1'b0;
        guard = 0;
        while (!found && guard < 10) begin
            tick0();
            rd(2'd2, v);
            if (v == 32'd1) found = 1'b1;
            guard++;
        end
        check("collide_reach_1", {31'd0, found}, 32'd1);
        tick(1'b1, 2'd0, 32'h9);
        rd(2'd0, v); check("collide_ctrl_kept", v, 32'h9);
        check("collide_irq", {31'd0, bus.irq}, 32'd0);
        tick0();
        rd(2'd0, v); check("collide_ctrl_after", v, 32'h8);
        check("collide_irq_after", {31'd0, bus.irq}, 32'd0);
        tick(1'b1, 2'd0, 32'd0);

        // Async reset mid-count
        tick(1'b1, 2'd1, 32'd20);
        tick(1'b1, 2'd0, 32'h9);
        for (int i = 0; i < 4; i++) tick0();
        rd(2'd2, v); check("prereset_count", v, 32'd17);
        #1;
        reset_n = 1'b0;
        #1;
        rd(2'd2, v); check("async_rst_count", v, 32'd0);
        check("async_rst_irq", {31'd0, bus.irq}, 32'd0);
        rd(2'd0, v); check("async_rst_ctrl", v, 32'd0);
        rd(2'd1, v); check("async_rst_preset", v, RST_PRESET);
        model_reset();
        reset_n = 1'b1;

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 400; cyc++) begin
            int op;
            op = int'($urandom_range(0, 15));
            if (op < 2) begin
                tick(1'b1, 2'd0, $urandom);
            end else if (op == 2) begin
                tick(1'b1, 2'd1, 32'($urandom_range(0, 6)));
            end else if (op == 3) begin
                tick(1'b1, 2'($urandom_range(2, 3)), $urandom);
            end else begin
                tick0();
            end
            for (int a = 0; a < 4; a++) begin
                rd(2'(a), v);
                check($sformatf("rand_rd%0d", a), v, m_read(2'(a)));
            end
            check("rand_irq", {31'd0, bus.irq}, {31'd0, m_flag & m_ctrl[3]});
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                #1;
                rd(2'd2, v); check("rand_rst_count", v, 32'd0);
                check("rand_rst_irq", {31'd0, bus.irq}, 32'd0);
                model_reset();
                reset_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
